// File: rtl/exec_unit_p.sv
// Parametrised execute stage: decodes the 4-bit opcode map and drives
// register write-back, the data-memory handshake and the program counter.
// Every output is a flop; nothing combinational reaches a port.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_EXEC     | ready; an instruction is accepted when INSTR_VALID=1
// ST_MEM_WAIT | LD/ST issued, MEM_REQ held until MEM_ACK
// ST_HALT     | HLT executed; only RESET_N leaves this state

module exec_unit_p #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              CLK_EX,
    input  logic              RESET_N,
    input  logic              INSTR_VALID,
    input  logic [3:0]        OP_CODE,
    input  logic [1:0]        COND,
    input  logic [DATA_W-1:0] REG_A,
    input  logic [DATA_W-1:0] REG_B,
    input  logic [7:0]        OP_DATA,
    input  logic [DATA_W-1:0] RAM_OUT,
    input  logic              MEM_ACK,
    output logic [PC_W-1:0]   P_COUNT,
    output logic [DATA_W-1:0] REG_IN,
    output logic              REG_WEN,
    output logic [DATA_W-1:0] RAM_IN,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic              BUSY,
    output logic              HALTED,
    output logic [2:0]        FLAGS
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_SL  = 4'h5;
    localparam logic [3:0] OP_SR  = 4'h6;
    localparam logic [3:0] OP_SRA = 4'h7;
    localparam logic [3:0] OP_LDL = 4'h8;
    localparam logic [3:0] OP_LDH = 4'h9;
    localparam logic [3:0] OP_CMP = 4'ha;
    localparam logic [3:0] OP_JCC = 4'hb;
    localparam logic [3:0] OP_JMP = 4'hc;
    localparam logic [3:0] OP_LD  = 4'hd;
    localparam logic [3:0] OP_ST  = 4'he;
    localparam logic [3:0] OP_HLT = 4'hf;

    typedef enum logic [1:0] {
        ST_EXEC     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W:0]   add_full;
    logic [DATA_W:0]   sub_full;
    logic [SH_W-1:0]   sh_amt;
    logic [DATA_W-1:0] alu_res;
    logic [2:0]        alu_flags;
    logic              cond_true;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_tgt;

    // Operand datapath: one result per opcode plus the {N,C,Z} it would produce.
    always_comb begin
        add_full = {1'b0, REG_A} + {1'b0, REG_B};
        sub_full = {1'b0, REG_A} - {1'b0, REG_B};
        sh_amt   = REG_B[SH_W-1:0];
        alu_res  = REG_B;
        case (OP_CODE)
            OP_ADD:         alu_res = add_full[DATA_W-1:0];
            OP_SUB, OP_CMP: alu_res = sub_full[DATA_W-1:0];
            OP_AND:         alu_res = REG_A & REG_B;
            OP_OR:          alu_res = REG_A | REG_B;
            OP_SL:          alu_res = REG_A << sh_amt;
            OP_SR:          alu_res = REG_A >> sh_amt;
            OP_SRA:         alu_res = $unsigned($signed(REG_A) >>> sh_amt);
            OP_LDL: begin
                alu_res       = REG_A;
                alu_res[7:0]  = OP_DATA;
            end
            OP_LDH: begin
                alu_res       = REG_A;
                alu_res[15:8] = OP_DATA;
            end
            default:        alu_res = REG_B;
        endcase
        // sub_full's top bit is the borrow, i.e. A < B unsigned.
        alu_flags = {alu_res[DATA_W-1],
                     (OP_CODE == OP_ADD) ? add_full[DATA_W] : sub_full[DATA_W],
                     (alu_res == '0)};
        case (COND)
            2'd0:    cond_true = FLAGS[0];
            2'd1:    cond_true = ~FLAGS[0];
            2'd2:    cond_true = FLAGS[1];
            default: cond_true = FLAGS[2];
        endcase
        pc_inc = P_COUNT + PC_W'(1);
        pc_tgt = PC_W'(OP_DATA);
    end

    // Sequencer: accepts instructions, runs the memory handshake, holds in halt.
    always_ff @(posedge CLK_EX or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_EXEC;
            P_COUNT <= RESET_PC;
            REG_IN  <= '0;
            REG_WEN <= 1'b0;
            RAM_IN  <= '0;
            MEM_REQ <= 1'b0;
            MEM_WE  <= 1'b0;
            BUSY    <= 1'b0;
            HALTED  <= 1'b0;
            FLAGS   <= 3'b000;
        end else begin
            REG_WEN <= 1'b0;
            case (state)
                ST_EXEC: begin
                    if (INSTR_VALID) begin
                        case (OP_CODE)
                            OP_MOV, OP_AND, OP_OR, OP_SL, OP_SR, OP_SRA, OP_LDL, OP_LDH: begin
                                REG_IN  <= alu_res;
                                REG_WEN <= 1'b1;
                                P_COUNT <= pc_inc;
                            end
                            OP_ADD, OP_SUB: begin
                                REG_IN  <= alu_res;
                                REG_WEN <= 1'b1;
                                FLAGS   <= alu_flags;
                                P_COUNT <= pc_inc;
                            end
                            OP_CMP: begin
                                FLAGS   <= alu_flags;
                                P_COUNT <= pc_inc;
                            end
                            OP_JCC: P_COUNT <= cond_true ? pc_tgt : pc_inc;
                            OP_JMP: P_COUNT <= pc_tgt;
                            OP_LD: begin
                                MEM_REQ <= 1'b1;
                                MEM_WE  <= 1'b0;
                                BUSY    <= 1'b1;
                                state   <= ST_MEM_WAIT;
                            end
                            OP_ST: begin
                                MEM_REQ <= 1'b1;
                                MEM_WE  <= 1'b1;
                                RAM_IN  <= REG_A;
                                BUSY    <= 1'b1;
                                state   <= ST_MEM_WAIT;
                            end
                            OP_HLT: begin
                                BUSY    <= 1'b1;
                                HALTED  <= 1'b1;
                                state   <= ST_HALT;
                            end
                        endcase
                    end
                end
                ST_MEM_WAIT: begin
                    if (MEM_ACK) begin
                        // MEM_WE still tells a store from a load at the ack edge.
                        if (!MEM_WE) begin
                            REG_IN  <= RAM_OUT;
                            REG_WEN <= 1'b1;
                        end
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        BUSY    <= 1'b0;
                        P_COUNT <= pc_inc;
                        state   <= ST_EXEC;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state  <= ST_EXEC;
                    BUSY   <= 1'b0;
                    HALTED <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit_p.sv
// Bench for exec_unit_p: a 16/8 instance exercised with directed and random
// instructions against a reference model, plus a 32/10 instance for width checks.

module tb_exec_unit_p;

    localparam logic [3:0] OP_MOV = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4, OP_SL  = 4'h5, OP_SR  = 4'h6, OP_SRA = 4'h7;
    localparam logic [3:0] OP_LDL = 4'h8, OP_LDH = 4'h9, OP_CMP = 4'ha, OP_JCC = 4'hb;
    localparam logic [3:0] OP_JMP = 4'hc, OP_LD  = 4'hd, OP_ST  = 4'he, OP_HLT = 4'hf;

    logic CLK_EX = 1'b0;
    always #5 CLK_EX = ~CLK_EX;

    logic        rst0_n, valid0, ack0;
    logic [3:0]  op0;
    logic [1:0]  cond0;
    logic [15:0] a0, b0, ram_out0, regin0, ram_in0;
    logic [7:0]  d0, pc0;
    logic        wen0, req0, we0, busy0, halted0;
    logic [2:0]  flags0;

    logic        rst1_n, valid1, ack1;
    logic [3:0]  op1;
    logic [1:0]  cond1;
    logic [31:0] a1, b1, ram_out1, regin1, ram_in1;
    logic [7:0]  d1;
    logic [9:0]  pc1;
    logic        wen1, req1, we1, busy1, halted1;
    logic [2:0]  flags1;

    exec_unit_p dut0 (
        .CLK_EX(CLK_EX), .RESET_N(rst0_n), .INSTR_VALID(valid0), .OP_CODE(op0), .COND(cond0),
        .REG_A(a0), .REG_B(b0), .OP_DATA(d0), .RAM_OUT(ram_out0), .MEM_ACK(ack0),
        .P_COUNT(pc0), .REG_IN(regin0), .REG_WEN(wen0), .RAM_IN(ram_in0), .MEM_REQ(req0),
        .MEM_WE(we0), .BUSY(busy0), .HALTED(halted0), .FLAGS(flags0)
    );

    exec_unit_p #(.DATA_W(32), .PC_W(10), .RESET_PC(10'h005)) dut1 (
        .CLK_EX(CLK_EX), .RESET_N(rst1_n), .INSTR_VALID(valid1), .OP_CODE(op1), .COND(cond1),
        .REG_A(a1), .REG_B(b1), .OP_DATA(d1), .RAM_OUT(ram_out1), .MEM_ACK(ack1),
        .P_COUNT(pc1), .REG_IN(regin1), .REG_WEN(wen1), .RAM_IN(ram_in1), .MEM_REQ(req1),
        .MEM_WE(we1), .BUSY(busy1), .HALTED(halted1), .FLAGS(flags1)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  pc;
        logic [2:0]  fl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state (architectural view only).
    int   m_pc;
    bit   m_z, m_c, m_n, m_halt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write-back pulse must match the oldest expectation.
    always @(negedge CLK_EX) begin
        if (rst0_n && wen0) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_unexpected: REG_IN=%0h with no write-back pending", regin0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_data", regin0, mon_e.d);
                chk("wb_pc", pc0, mon_e.pc);
                chk("wb_flags", flags0, mon_e.fl);
            end
        end
    end

    task automatic reset0();
        @(negedge CLK_EX);
        rst0_n = 1'b0;
        valid0 = 1'b0;
        ack0   = 1'b0;
        #2;
        chk("sb_drain_at_reset", sb.size(), 0);
        sb.delete();
        chk("rst_pc", pc0, 0);
        chk("rst_regin", regin0, 0);
        chk("rst_ramin", ram_in0, 0);
        chk("rst_strobes", {wen0, req0, we0, busy0, halted0}, 0);
        chk("rst_flags", flags0, 0);
        @(negedge CLK_EX);
        rst0_n = 1'b1;
        m_pc = 0; m_z = 0; m_c = 0; m_n = 0; m_halt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            op0 = 4'($urandom);
            @(posedge CLK_EX); #1;
            chk("idle_pc", pc0, m_pc);
            chk("idle_flags", flags0, {m_n, m_c, m_z});
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] d, input logic [1:0] cond, input int dly,
                         input logic [15:0] rdata);
        int   ai, bi, s, r, npc;
        bit   wb, mem, take;
        exp_t e;
        ai = a; bi = b; s = bi % 16; r = 0; wb = 0; take = 0;
        mem = (op == OP_LD) || (op == OP_ST);
        npc = (m_pc + 1) % 256;
        @(negedge CLK_EX);
        valid0 = 1'b1; op0 = op; a0 = a; b0 = b; d0 = d; cond0 = cond;
        ack0 = mem ? 1'b0 : 1'($urandom_range(0, 1));
        ram_out0 = 16'($urandom);
        if (m_halt) begin
            @(posedge CLK_EX); #1;
            valid0 = 1'b0; ack0 = 1'b0;
            chk("halt_pc_frozen", pc0, m_pc);
            chk("halt_busy", busy0, 1);
            chk("halt_halted", halted0, 1);
            return;
        end
        case (op)
            OP_MOV: begin r = bi; wb = 1; end
            OP_ADD: begin
                r = ai + bi; m_c = (r > 65535); r = r & 32'hFFFF;
                m_z = (r == 0); m_n = (r >= 32768); wb = 1;
            end
            OP_SUB, OP_CMP: begin
                m_c = (ai < bi); r = (ai - bi) & 32'hFFFF;
                m_z = (r == 0); m_n = (r >= 32768); wb = (op == OP_SUB);
            end
            OP_AND: begin r = ai & bi; wb = 1; end
            OP_OR:  begin r = ai | bi; wb = 1; end
            OP_SL:  begin r = (ai << s) & 32'hFFFF; wb = 1; end
            OP_SR:  begin r = ai >> s; wb = 1; end
            OP_SRA: begin
                r = ai >> s;
                if (ai >= 32768) r = r | (32'hFFFF & ~(32'hFFFF >> s));
                wb = 1;
            end
            OP_LDL: begin r = (ai & 32'hFF00) | int'(d); wb = 1; end
            OP_LDH: begin r = (ai & 32'h00FF) | (int'(d) << 8); wb = 1; end
            OP_JCC: begin
                case (cond)
                    2'd0: take = m_z;
                    2'd1: take = !m_z;
                    2'd2: take = m_c;
                    default: take = m_n;
                endcase
                if (take) npc = int'(d);
            end
            OP_JMP: npc = int'(d);
            OP_LD:  begin r = rdata; wb = 1; end
            OP_ST:  ;
            default: begin npc = m_pc; m_halt = 1; end
        endcase
        if (wb) begin
            e.d = r[15:0]; e.pc = npc[7:0]; e.fl = {m_n, m_c, m_z};
            sb.push_back(e);
        end
        @(posedge CLK_EX); #1;
        valid0 = 1'b0; ack0 = 1'b0;
        if (mem) begin
            chk("mem_req", req0, 1);
            chk("mem_we", we0, op == OP_ST);
            chk("mem_busy", busy0, 1);
            chk("mem_pc_hold", pc0, m_pc);
            if (op == OP_ST) chk("st_ram_in", ram_in0, a);
            repeat (dly) begin
                ack0 = 1'b0;
                ram_out0 = 16'($urandom);
                @(posedge CLK_EX); #1;
                chk("stall_req", req0, 1);
                chk("stall_busy", busy0, 1);
                chk("stall_pc", pc0, m_pc);
            end
            ack0 = 1'b1;
            ram_out0 = rdata;
            @(posedge CLK_EX); #1;
            ack0 = 1'b0;
            chk("ack_req_drop", {req0, we0}, 0);
        end
        m_pc = npc;
        chk("pc", pc0, m_pc);
        chk("flags", flags0, {m_n, m_c, m_z});
        chk("busy_halted", {busy0, halted0}, {m_halt, m_halt});
    endtask

    task automatic issue1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] d);
        @(negedge CLK_EX);
        valid1 = 1'b1; op1 = op; a1 = a; b1 = b; d1 = d; cond1 = 2'd0;
        @(posedge CLK_EX); #1;
        valid1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rop;
        logic [15:0] ra;
        rst0_n = 1'b0; valid0 = 1'b0; ack0 = 1'b0; op0 = '0; cond0 = '0;
        a0 = '0; b0 = '0; d0 = '0; ram_out0 = '0;
        rst1_n = 1'b0; valid1 = 1'b0; ack1 = 1'b0; op1 = '0; cond1 = '0;
        a1 = '0; b1 = '0; d1 = '0; ram_out1 = '0;

        // Basic write-back, idle hold
        reset0();
        issue(OP_MOV, 16'h0000, 16'h1234, 8'h00, 2'd0, 0, 16'h0);
        chk("mov_pc_literal", pc0, 8'h01);
        idle(3);

        // Flags and conditional jumps
        issue(OP_ADD, 16'hFFFF, 16'h0001, 8'h00, 2'd0, 0, 16'h0);
        chk("add_flags_literal", flags0, 3'b011);
        issue(OP_CMP, 16'h0003, 16'h0005, 8'h00, 2'd0, 0, 16'h0);
        chk("cmp_flags_literal", flags0, 3'b110);
        issue(OP_JCC, 16'h0000, 16'h0000, 8'h40, 2'd2, 0, 16'h0);
        chk("jcc_taken_literal", pc0, 8'h40);
        issue(OP_JCC, 16'h0000, 16'h0000, 8'h10, 2'd0, 0, 16'h0);
        chk("jcc_not_taken_literal", pc0, 8'h41);

        // Shifts and byte loads
        issue(OP_SRA, 16'h8000, 16'h0004, 8'h00, 2'd0, 0, 16'h0);
        issue(OP_SR,  16'h8000, 16'h0004, 8'h00, 2'd0, 0, 16'h0);
        issue(OP_SL,  16'h0001, 16'h000F, 8'h00, 2'd0, 0, 16'h0);
        issue(OP_LDH, 16'h00AB, 16'h0000, 8'hCD, 2'd0, 0, 16'h0);
        issue(OP_LDL, 16'h1234, 16'h0000, 8'h99, 2'd0, 0, 16'h0);

        // Memory handshake: stalled load, fastest store, back-to-back follow-up
        issue(OP_LD, 16'h0000, 16'h0000, 8'h00, 2'd0, 3, 16'hBEEF);
        issue(OP_ST, 16'h5A5A, 16'h0000, 8'h00, 2'd0, 0, 16'h0);
        issue(OP_MOV, 16'h0000, 16'h7777, 8'h00, 2'd0, 0, 16'h0);

        // PC wrap
        issue(OP_JMP, 16'h0000, 16'h0000, 8'hFF, 2'd0, 0, 16'h0);
        issue(OP_ADD, 16'h0002, 16'h0003, 8'h00, 2'd0, 0, 16'h0);
        chk("pc_wrap_literal", pc0, 8'h00);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            rop = $urandom_range(0, 14);
            ra  = 16'($urandom);
            issue(4'(rop), ra, ($urandom_range(0, 3) == 0) ? ra : 16'($urandom),
                  8'($urandom), 2'($urandom), $urandom_range(0, 3), 16'($urandom));
            if ($urandom_range(0, 7) == 0) idle(1);
        end

        // Halt is sticky
        issue(OP_HLT, 16'h0000, 16'h0000, 8'h00, 2'd0, 0, 16'h0);
        issue(OP_MOV, 16'h0000, 16'h4321, 8'h00, 2'd0, 0, 16'h0);
        issue(OP_JMP, 16'h0000, 16'h0000, 8'h22, 2'd0, 0, 16'h0);
        issue(OP_LD,  16'h0000, 16'h0000, 8'h00, 2'd0, 0, 16'h1111);

        // Reset in the middle of a memory wait
        reset0();
        issue(OP_MOV, 16'h0000, 16'h1111, 8'h00, 2'd0, 0, 16'h0);
        issue(OP_MOV, 16'h0000, 16'h2222, 8'h00, 2'd0, 0, 16'h0);
        @(negedge CLK_EX);
        valid0 = 1'b1; op0 = OP_LD;
        @(posedge CLK_EX); #1;
        valid0 = 1'b0;
        chk("ld_req_before_rst", {req0, busy0}, 2'b11);
        #2;
        rst0_n = 1'b0;
        #1;
        chk("midrst_req", req0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_wen", wen0, 0);
        chk("midrst_pc", pc0, 0);
        chk("midrst_regin", regin0, 0);
        @(negedge CLK_EX);
        ack0 = 1'b1; ram_out0 = 16'hDEAD;
        rst0_n = 1'b1;
        m_pc = 0; m_z = 0; m_c = 0; m_n = 0; m_halt = 0;
        @(posedge CLK_EX); #1;
        ack0 = 1'b0;
        chk("post_rst_pc", pc0, 0);
        chk("post_rst_req", req0, 0);
        idle(2);

        // Wide instance: DATA_W=32, PC_W=10, RESET_PC=5
        #1;
        chk("w_rst_pc", pc1, 10'h005);
        chk("w_rst_busy", {busy1, halted1, req1}, 0);
        @(negedge CLK_EX);
        rst1_n = 1'b1;
        issue1(OP_LDH, 32'h12345678, 32'h0, 8'hCD);
        chk("w_ldh", regin1, 32'h1234CD78);
        chk("w_ldh_wen", wen1, 1);
        chk("w_ldh_pc", pc1, 10'h006);
        issue1(OP_SRA, 32'h80000000, 32'h00000024, 8'h00);
        chk("w_sra", regin1, 32'hF8000000);
        issue1(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 8'h00);
        chk("w_add", regin1, 32'h0);
        chk("w_add_flags", flags1, 3'b011);
        issue1(OP_JMP, 32'h0, 32'h0, 8'hFF);
        chk("w_jmp_pc", pc1, 10'h0FF);
        chk("w_jmp_wen", wen1, 0);
        issue1(OP_MOV, 32'h0, 32'hCAFEF00D, 8'h00);
        chk("w_pc_carry", pc1, 10'h100);
        chk("w_mov", regin1, 32'hCAFEF00D);

        @(negedge CLK_EX);
        chk("sb_drain_final", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
